// File: rtl/psys_route_pkg.sv
// Shared widths and slot-offset helper for the poly-systolic data route
// width converters (upsizer and downsizer).
package psys_route_pkg;

  localparam int DEFAULT_IN_W  = 1536;
  localparam int DEFAULT_RATIO = 4;

  function automatic int beat_slot_lo(input int i, input int in_w);
    return i * in_w;
  endfunction

endpackage

// File: rtl/axis_upsizer_param.sv
// AXI-Stream width upsizer: packs RATIO beats of IN_W bits into one word,
// slot 0 in the LSBs, with per-slot tlast/tuser/keep side-band.
module axis_upsizer_param
  import psys_route_pkg::*;
#(
  parameter int IN_W          = DEFAULT_IN_W,
  parameter int RATIO         = DEFAULT_RATIO,
  parameter bit FLUSH_ON_LAST = 1'b1,
  parameter int CNT_W         = $clog2(RATIO)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [RATIO*IN_W-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [RATIO-1:0]      m_axis_tlast,
  output logic [RATIO-1:0]      m_axis_tuser,
  output logic [RATIO-1:0]      m_axis_tkeep
);

  localparam int OUT_W = RATIO * IN_W;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]            cnt;
  logic [RATIO-1:0][IN_W-1:0]  acc_data;
  logic [RATIO-1:0]            acc_last;
  logic [RATIO-1:0]            acc_user;
  logic [RATIO-1:0]            acc_keep;
  logic [RATIO-1:0]            slot_hot;
  logic [RATIO-1:0]            last_hot;
  logic [RATIO-1:0]            user_hot;
  logic                        closing_slot;
  logic                        accept;
  logic                        close;
  logic [OUT_W-1:0]            word_d;

  assign closing_slot = (cnt == LAST_SLOT)
                      | (FLUSH_ON_LAST & s_axis_tlast);
  assign s_axis_tready = ~closing_slot
                       | ~m_axis_tvalid
                       | m_axis_tready;
  assign accept = s_axis_tvalid & s_axis_tready;
  assign close  = accept & closing_slot;

  assign slot_hot = RATIO'(1) << cnt;
  assign last_hot = slot_hot & {RATIO{s_axis_tlast}};
  assign user_hot = slot_hot & {RATIO{s_axis_tuser}};

  // Unfilled slots above cnt are still zero, since the accumulator
  // is cleared on every close.
  always_comb begin
    word_d = '0;
    for (int i = 0; i < RATIO; i++) begin
      word_d[beat_slot_lo(i, IN_W) +: IN_W] =
        slot_hot[i] ? s_axis_tdata : acc_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      acc_data      <= '0;
      acc_last      <= '0;
      acc_user      <= '0;
      acc_keep      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tkeep  <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (close) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= word_d;
        m_axis_tlast  <= acc_last | last_hot;
        m_axis_tuser  <= acc_user | user_hot;
        m_axis_tkeep  <= acc_keep | slot_hot;
        cnt           <= '0;
        acc_data      <= '0;
        acc_last      <= '0;
        acc_user      <= '0;
        acc_keep      <= '0;
      end else if (accept) begin
        for (int i = 0; i < RATIO; i++) begin
          if (slot_hot[i]) begin
            acc_data[i] <= s_axis_tdata;
          end
        end
        acc_last <= acc_last | last_hot;
        acc_user <= acc_user | user_hot;
        acc_keep <= acc_keep | slot_hot;
        cnt      <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_upsizer_param.sv
// Scoreboard bench for axis_upsizer_param: default flush, no-flush and
// a narrow RATIO=3 instance under random valid/ready.
module tb_axis_upsizer_param;

  localparam int W0 = 1536;
  localparam int R0 = 4;
  localparam int W2 = 64;
  localparam int R2 = 3;
  localparam int MW = W0 * R0;

  typedef struct packed {
    logic [MW-1:0] data;
    logic [3:0]    last;
    logic [3:0]    user;
    logic [3:0]    keep;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [W0-1:0]    s_tdata0, s_tdata1;
  logic [W2-1:0]    s_tdata2;
  logic             s_tvalid0, s_tvalid1, s_tvalid2;
  logic             s_tready0, s_tready1, s_tready2;
  logic             s_tlast0, s_tlast1, s_tlast2;
  logic             s_tuser0, s_tuser1, s_tuser2;
  logic [MW-1:0]    m_tdata0, m_tdata1;
  logic [R2*W2-1:0] m_tdata2;
  logic             m_tvalid0, m_tvalid1, m_tvalid2;
  logic             m_tready0, m_tready1, m_tready2;
  logic [3:0]       m_tlast0, m_tlast1, m_tuser0, m_tuser1;
  logic [3:0]       m_tkeep0, m_tkeep1;
  logic [2:0]       m_tlast2, m_tuser2, m_tkeep2;

  axis_upsizer_param #(.IN_W(W0), .RATIO(R0), .FLUSH_ON_LAST(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata0), .s_axis_tvalid(s_tvalid0),
    .s_axis_tready(s_tready0), .s_axis_tlast(s_tlast0),
    .s_axis_tuser(s_tuser0), .m_axis_tdata(m_tdata0),
    .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready0),
    .m_axis_tlast(m_tlast0), .m_axis_tuser(m_tuser0),
    .m_axis_tkeep(m_tkeep0)
  );

  axis_upsizer_param #(.IN_W(W0), .RATIO(R0), .FLUSH_ON_LAST(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata1), .s_axis_tvalid(s_tvalid1),
    .s_axis_tready(s_tready1), .s_axis_tlast(s_tlast1),
    .s_axis_tuser(s_tuser1), .m_axis_tdata(m_tdata1),
    .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready1),
    .m_axis_tlast(m_tlast1), .m_axis_tuser(m_tuser1),
    .m_axis_tkeep(m_tkeep1)
  );

  axis_upsizer_param #(.IN_W(W2), .RATIO(R2), .FLUSH_ON_LAST(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata2), .s_axis_tvalid(s_tvalid2),
    .s_axis_tready(s_tready2), .s_axis_tlast(s_tlast2),
    .s_axis_tuser(s_tuser2), .m_axis_tdata(m_tdata2),
    .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready2),
    .m_axis_tlast(m_tlast2), .m_axis_tuser(m_tuser2),
    .m_axis_tkeep(m_tkeep2)
  );

  int n_chk = 0;
  int n_fail = 0;
  word_t q0[$], q1[$], q2[$];
  logic [MW-1:0] md[3];
  logic [3:0] ml[3], mu[3], mk[3];
  int mc[3];
  bit done;

  task automatic chk(input string tag, input logic [MW-1:0] obs,
                     input logic [MW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (low 64 bits)",
               tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [W0-1:0] pat(input int k);
    logic [W0-1:0] v;
    for (int j = 0; j < W0 / 32; j++)
      v[j*32 +: 32] = (32'(k) * 32'h9E3779B1) ^ 32'(j);
    return v;
  endfunction

  task automatic model_clear(input int d);
    md[d] = '0; ml[d] = '0; mu[d] = '0; mk[d] = '0; mc[d] = 0;
  endtask

  // Reference packing: slot n of a word sits at bits [n*w +: w].
  task automatic model_beat(input int d, input logic [W0-1:0] data,
                            input logic last, input logic user);
    int r = (d == 2) ? R2 : R0;
    int w = (d == 2) ? W2 : W0;
    bit fl = (d != 1);
    logic [MW-1:0] ext;
    word_t e;
    ext = (d == 2) ? MW'(data[W2-1:0]) : MW'(data);
    md[d] = md[d] | (ext << (mc[d] * w));
    ml[d] = ml[d] | (4'(last) << mc[d]);
    mu[d] = mu[d] | (4'(user) << mc[d]);
    mk[d] = mk[d] | (4'(1) << mc[d]);
    if (mc[d] == r - 1 || (fl && last)) begin
      e.data = md[d]; e.last = ml[d]; e.user = mu[d]; e.keep = mk[d];
      case (d)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
      model_clear(d);
    end else begin
      mc[d]++;
    end
  endtask

  task automatic cmp(input int d, input word_t o);
    word_t e;
    int sz;
    sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      chk($sformatf("d%0d_sb_pop", d), MW'(sz), MW'(1));
    end else begin
      case (d)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("d%0d_data", d), o.data, e.data);
      chk($sformatf("d%0d_last", d), MW'(o.last), MW'(e.last));
      chk($sformatf("d%0d_user", d), MW'(o.user), MW'(e.user));
      chk($sformatf("d%0d_keep", d), MW'(o.keep), MW'(e.keep));
    end
  endtask

  task automatic send(input int d, input logic [W0-1:0] data,
                      input logic last, input logic user,
                      output int waits);
    int n = 0;
    logic ok = 1'b0;
    case (d)
      0: begin s_tdata0 = data; s_tlast0 = last; s_tuser0 = user; s_tvalid0 = 1'b1; end
      1: begin s_tdata1 = data; s_tlast1 = last; s_tuser1 = user; s_tvalid1 = 1'b1; end
      default: begin
        s_tdata2 = data[W2-1:0]; s_tlast2 = last; s_tuser2 = user; s_tvalid2 = 1'b1;
      end
    endcase
    do begin
      @(negedge clk);
      case (d)
        0: ok = s_tvalid0 & s_tready0;
        1: ok = s_tvalid1 & s_tready1;
        default: ok = s_tvalid2 & s_tready2;
      endcase
      if (ok) model_beat(d, data, last, user);
      @(posedge clk);
      #1;
      if (!ok) n++;
    end while (!ok && n < 200);
    chk($sformatf("d%0d_accept", d), MW'(ok), MW'(1));
    waits = n;
  endtask

  task automatic idle(input int d);
    case (d)
      0: begin s_tvalid0 = 1'b0; s_tlast0 = 1'b0; s_tuser0 = 1'b0; end
      1: begin s_tvalid1 = 1'b0; s_tlast1 = 1'b0; s_tuser1 = 1'b0; end
      default: begin
        s_tvalid2 = 1'b0; s_tlast2 = 1'b0; s_tuser2 = 1'b0;
        s_tdata2 = {$urandom, $urandom};
      end
    endcase
  endtask

  task automatic check_reset0();
    chk("rst_tvalid", MW'(m_tvalid0), MW'(0));
    chk("rst_tdata", m_tdata0, MW'(0));
    chk("rst_tlast", MW'(m_tlast0), MW'(0));
    chk("rst_tuser", MW'(m_tuser0), MW'(0));
    chk("rst_tkeep", MW'(m_tkeep0), MW'(0));
    chk("rst_sready", MW'(s_tready0), MW'(1));
  endtask

  logic [MW-1:0] p_data0, p_data2;
  bit p_stall0, p_stall2;

  always @(negedge clk) begin
    word_t o;
    if (rst_n && p_stall0) begin
      chk("d0_hold_v", MW'(m_tvalid0), MW'(1));
      chk("d0_hold_d", m_tdata0, p_data0);
    end
    p_stall0 = rst_n && m_tvalid0 && !m_tready0;
    p_data0 = m_tdata0;
    if (rst_n && m_tvalid0 && m_tready0) begin
      o.data = m_tdata0; o.last = m_tlast0; o.user = m_tuser0; o.keep = m_tkeep0;
      cmp(0, o);
    end
    if (rst_n && m_tvalid1 && m_tready1) begin
      o.data = m_tdata1; o.last = m_tlast1; o.user = m_tuser1; o.keep = m_tkeep1;
      cmp(1, o);
    end
    if (rst_n && p_stall2) begin
      chk("d2_hold_v", MW'(m_tvalid2), MW'(1));
      chk("d2_hold_d", MW'(m_tdata2), p_data2);
    end
    p_stall2 = rst_n && m_tvalid2 && !m_tready2;
    p_data2 = MW'(m_tdata2);
    if (rst_n && m_tvalid2 && m_tready2) begin
      o.data = MW'(m_tdata2); o.last = 4'(m_tlast2);
      o.user = 4'(m_tuser2); o.keep = 4'(m_tkeep2);
      cmp(2, o);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    s_tdata0 = '0; s_tdata1 = '0; s_tdata2 = '0;
    idle(0); idle(1); idle(2);
    m_tready0 = 1'b1; m_tready1 = 1'b1; m_tready2 = 1'b1;
    for (int d = 0; d < 3; d++) model_clear(d);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset0();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // back-to-back A..D, output valid for a single cycle
    for (int k = 1; k <= 4; k++) send(0, pat(k), 1'b0, 1'b0, w);
    idle(0);
    @(negedge clk);
    chk("t1_valid_hi", MW'(m_tvalid0), MW'(1));
    chk("t1_keep", MW'(m_tkeep0), MW'(4'b1111));
    @(negedge clk);
    chk("t1_valid_lo", MW'(m_tvalid0), MW'(0));
    @(posedge clk); #1;

    // output stall: only the 8th (closing) beat is held off
    m_tready0 = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(0, pat(10 + i), 1'b0, 1'b0, w);
          chk("t2_stall", MW'(w != 0), MW'(i == 7));
        end
        idle(0);
      end
      begin
        int n = 0;
        while (!m_tvalid0 && n < 50) begin @(negedge clk); n++; end
        chk("t2_first_valid", MW'(m_tvalid0), MW'(1));
        repeat (5) @(posedge clk);
        #1 m_tready0 = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;

    // early flush on tlast, then the next beat restarts at slot 0
    send(0, pat(20), 1'b0, 1'b1, w);
    send(0, pat(21), 1'b1, 1'b0, w);
    idle(0);
    @(negedge clk);
    chk("t3_keep", MW'(m_tkeep0), MW'(4'b0011));
    chk("t3_last", MW'(m_tlast0), MW'(4'b0010));
    chk("t3_user", MW'(m_tuser0), MW'(4'b0001));
    @(posedge clk); #1;
    for (int k = 22; k <= 25; k++) send(0, pat(k), 1'b0, 1'b0, w);
    idle(0);
    repeat (3) @(posedge clk); #1;

    // no-flush instance: tlast only recorded
    for (int k = 0; k < 4; k++) send(1, pat(30 + k), 1'(k == 1), 1'b0, w);
    idle(1);
    repeat (3) @(posedge clk); #1;

    // reset drops a partial word
    send(0, pat(40), 1'b0, 1'b0, w);
    send(0, pat(41), 1'b0, 1'b0, w);
    idle(0);
    rst_n = 1'b0;
    @(posedge clk);
    model_clear(0);
    @(negedge clk);
    check_reset0();
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 50; k <= 53; k++) send(0, pat(k), 1'b0, 1'b0, w);
    idle(0);
    repeat (3) @(posedge clk); #1;

    // random valid/ready on the narrow instance
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [W0-1:0] v;
          while ($urandom_range(1, 0) == 1) begin
            idle(2);
            @(posedge clk); #1;
          end
          v = '0;
          v[W2-1:0] = {$urandom, $urandom};
          send(2, v, 1'($urandom_range(3, 0) == 0),
               1'($urandom_range(1, 0)), w);
        end
        idle(2);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          m_tready2 = 1'($urandom_range(1, 0));
        end
      end
    join
    m_tready2 = 1'b1;
    for (int n = 0; n < 200 && (q0.size() + q1.size() + q2.size()) != 0; n++)
      @(negedge clk);

    chk("q0_empty", MW'(q0.size()), MW'(0));
    chk("q1_empty", MW'(q1.size()), MW'(0));
    chk("q2_empty", MW'(q2.size()), MW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
